// File: rtl/dm_hart_ctrl_pkg.sv
// Shared types and constants for the debug-module HART sequencer.
package dm_hart_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_HALT   = 3'd0,
    OP_RESUME = 3'd1,
    OP_READ   = 3'd2,
    OP_WRITE  = 3'd3,
    OP_STEP   = 3'd4
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_REG_ACC,
    S_STEP_RD,
    S_STEP_SET,
    S_STEP_WAIT,
    S_STEP_CLR,
    S_RESUME_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_NOT_SUPPORTED = 3'd2;
  localparam logic [2:0] ERR_HALT_RESUME   = 3'd4;

  localparam logic [15:0] DCSR_ADDR     = 16'h07B0;
  localparam int          DCSR_STEP_BIT = 2;

endpackage

// File: rtl/dm_hart_ctrl_timer.sv
// Wait watchdog: counts cycles while enabled, flags expiry on the LIMIT-th cycle.
module dm_hart_ctrl_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_reg <= '0;
    end else if (clear_i) begin
      count_reg <= '0;
    end else if (enable_i && !expired_o) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired_o = enable_i && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/dm_hart_ctrl.sv
// Abstract-command sequencer driving the HART halt/register/step/resume handshakes.
// Optional watchdog on HART waits: define DM_HART_CTRL_TIMEOUT_EN.
module dm_hart_ctrl
  import dm_hart_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic [2:0]  rsp_err_o,
  output logic        halted_o,
  output logic        busy_o,
  output logic        hart_halt_req_o,
  output logic        hart_rd_wr_en_o,
  output logic        hart_rd_wr_o,
  output logic [15:0] hart_addr_o,
  output logic [31:0] hart_wdata_o,
  input  logic [31:0] hart_rdata_i,
  input  logic        hart_halt_ack_i,
  input  logic        hart_resume_ack_i,
  input  logic        hart_stepping_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dm_hart_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  state_e      state_reg, state_next;
  logic        halted_reg, halted_next;
  logic [2:0]  op_reg, op_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] shadow_reg, shadow_next;
  logic [31:0] rsp_data_reg, rsp_data_next;
  logic [2:0]  rsp_err_reg, rsp_err_next;
  logic        step_to_reg, step_to_next;
  logic        respond;
  logic [2:0]  resp_err;
  logic [31:0] resp_data;
  logic        timer_expired;

`ifdef DM_HART_CTRL_TIMEOUT_EN
  logic wait_state;
  assign wait_state = (state_reg == S_HALT_WAIT) || (state_reg == S_STEP_WAIT) ||
                      (state_reg == S_RESUME_WAIT);

  dm_hart_ctrl_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (!wait_state),
    .enable_i  (wait_state),
    .expired_o (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg    <= S_IDLE;
      halted_reg   <= 1'b0;
      op_reg       <= '0;
      wdata_reg    <= '0;
      shadow_reg   <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= ERR_NONE;
      step_to_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      halted_reg   <= halted_next;
      op_reg       <= op_next;
      wdata_reg    <= wdata_next;
      shadow_reg   <= shadow_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
      step_to_reg  <= step_to_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    halted_next   = halted_reg;
    op_next       = op_reg;
    wdata_next    = wdata_reg;
    shadow_next   = shadow_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    step_to_next  = step_to_reg;
    respond       = 1'b0;
    resp_err      = ERR_NONE;
    resp_data     = '0;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_next      = cmd_op_i;
          wdata_next   = cmd_wdata_i;
          step_to_next = 1'b0;
          case (cmd_op_i)
            OP_HALT: begin
              if (halted_reg) respond = 1'b1;
              else            state_next = S_HALT_WAIT;
            end
            OP_RESUME: begin
              if (!halted_reg) begin
                respond  = 1'b1;
                resp_err = ERR_HALT_RESUME;
              end else begin
                state_next = S_RESUME_WAIT;
              end
            end
            OP_READ, OP_WRITE: begin
              if (!halted_reg) begin
                respond  = 1'b1;
                resp_err = ERR_HALT_RESUME;
              end else if (cmd_addr_i != DCSR_ADDR) begin
                respond  = 1'b1;
                resp_err = ERR_NOT_SUPPORTED;
              end else begin
                state_next = S_REG_ACC;
              end
            end
            OP_STEP: begin
              if (!halted_reg) begin
                respond  = 1'b1;
                resp_err = ERR_HALT_RESUME;
              end else begin
                state_next = S_STEP_RD;
              end
            end
            default: begin
              respond  = 1'b1;
              resp_err = ERR_NOT_SUPPORTED;
            end
          endcase
        end
      end
      S_HALT_WAIT: begin
        if (hart_halt_ack_i) begin
          halted_next = 1'b1;
          respond     = 1'b1;
        end else if (timer_expired) begin
          respond  = 1'b1;
          resp_err = ERR_HALT_RESUME;
        end
      end
      S_REG_ACC: begin
        respond = 1'b1;
        if (op_reg == OP_READ) resp_data = hart_rdata_i;
      end
      S_STEP_RD: begin
        shadow_next = hart_rdata_i;
        state_next  = S_STEP_SET;
      end
      S_STEP_SET: state_next = S_STEP_WAIT;
      S_STEP_WAIT: begin
        // A step timeout still runs STEP_CLR so the HART is not left single-stepping.
        if (hart_stepping_i) begin
          state_next = S_STEP_CLR;
        end else if (timer_expired) begin
          step_to_next = 1'b1;
          state_next   = S_STEP_CLR;
        end
      end
      S_STEP_CLR: begin
        respond  = 1'b1;
        resp_err = step_to_reg ? ERR_HALT_RESUME : ERR_NONE;
      end
      S_RESUME_WAIT: begin
        if (hart_resume_ack_i) begin
          halted_next = 1'b0;
          respond     = 1'b1;
        end else if (timer_expired) begin
          respond  = 1'b1;
          resp_err = ERR_HALT_RESUME;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (respond) begin
      state_next    = S_RESP;
      rsp_err_next  = resp_err;
      rsp_data_next = resp_data;
    end
  end

  always_comb begin
    hart_rd_wr_en_o = 1'b0;
    hart_rd_wr_o    = 1'b0;
    hart_addr_o     = '0;
    hart_wdata_o    = '0;
    case (state_reg)
      S_REG_ACC: begin
        hart_rd_wr_en_o = 1'b1;
        hart_addr_o     = DCSR_ADDR;
        if (op_reg == OP_WRITE) begin
          hart_rd_wr_o = 1'b1;
          hart_wdata_o = wdata_reg;
        end
      end
      S_STEP_RD: begin
        hart_rd_wr_en_o = 1'b1;
        hart_addr_o     = DCSR_ADDR;
      end
      S_STEP_SET: begin
        hart_rd_wr_en_o = 1'b1;
        hart_rd_wr_o    = 1'b1;
        hart_addr_o     = DCSR_ADDR;
        hart_wdata_o    = shadow_reg | (32'd1 << DCSR_STEP_BIT);
      end
      S_STEP_CLR: begin
        hart_rd_wr_en_o = 1'b1;
        hart_rd_wr_o    = 1'b1;
        hart_addr_o     = DCSR_ADDR;
        hart_wdata_o    = shadow_reg & ~(32'd1 << DCSR_STEP_BIT);
      end
      default: ;
    endcase
  end

  assign cmd_ready_o     = (state_reg == S_IDLE);
  assign busy_o          = (state_reg != S_IDLE);
  assign rsp_valid_o     = (state_reg == S_RESP);
  assign rsp_data_o      = rsp_data_reg;
  assign rsp_err_o       = rsp_err_reg;
  assign halted_o        = halted_reg;
  assign hart_halt_req_o = (state_reg == S_HALT_WAIT) ||
                           (halted_reg && (state_reg != S_RESUME_WAIT));

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Directed bench for dm_hart_ctrl with a transaction-level command model and per-cycle monitor.
module tb_dm_hart_ctrl;

`ifdef DM_HART_CTRL_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i = '0;
  logic [15:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic [2:0]  rsp_err_o;
  logic        halted_o;
  logic        busy_o;
  logic        hart_halt_req_o;
  logic        hart_rd_wr_en_o;
  logic        hart_rd_wr_o;
  logic [15:0] hart_addr_o;
  logic [31:0] hart_wdata_o;
  logic [31:0] hart_rdata_i = '0;
  logic        hart_halt_ack_i = 1'b0;
  logic        hart_resume_ack_i = 1'b0;
  logic        hart_stepping_i = 1'b0;

  dm_hart_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .cmd_op_i          (cmd_op_i),
    .cmd_addr_i        (cmd_addr_i),
    .cmd_wdata_i       (cmd_wdata_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_data_o        (rsp_data_o),
    .rsp_err_o         (rsp_err_o),
    .halted_o          (halted_o),
    .busy_o            (busy_o),
    .hart_halt_req_o   (hart_halt_req_o),
    .hart_rd_wr_en_o   (hart_rd_wr_en_o),
    .hart_rd_wr_o      (hart_rd_wr_o),
    .hart_addr_o       (hart_addr_o),
    .hart_wdata_o      (hart_wdata_o),
    .hart_rdata_i      (hart_rdata_i),
    .hart_halt_ack_i   (hart_halt_ack_i),
    .hart_resume_ack_i (hart_resume_ack_i),
    .hart_stepping_i   (hart_stepping_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    logic [31:0] wdata;
  } bus_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          m_halted = 1'b0;
  bit          in_flight = 1'b0;
  logic [2:0]  cur_op = '0;
  int          acc_cyc = 0;
  int          exp_cyc = 0;
  int          last_lat = 0;
  logic [2:0]  exp_err = '0;
  logic [31:0] exp_data = '0;
  bit          exp_halted_after = 1'b0;
  bus_t        bus_q[$];
  logic [31:0] wr_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle monitor against the command-level model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy_o, in_flight);
      chk("ready", cmd_ready_o, !in_flight);
      if (hart_rd_wr_en_o) begin
        chk("strobe_expected", bus_q.size() != 0, 1);
        if (bus_q.size() != 0) begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_rw", hart_rd_wr_o, e.rw);
          chk("bus_addr", hart_addr_o, 32'h07B0);
          if (e.rw) begin
            chk("bus_wdata", hart_wdata_o, e.wdata);
            wr_log.push_back(hart_wdata_o);
          end
        end
      end
      if (rsp_valid_o) begin
        chk("rsp_expected", in_flight, 1);
        if (in_flight) begin
          chk("rsp_cycle", cyc, exp_cyc);
          chk("rsp_err", rsp_err_o, exp_err);
          chk("rsp_data", rsp_data_o, exp_data);
          chk("bus_ops_done", bus_q.size(), 0);
          last_lat = cyc - acc_cyc + 1;
          m_halted = exp_halted_after;
          in_flight = 1'b0;
        end
      end
      chk("halted", halted_o, m_halted);
      chk("halt_req", hart_halt_req_o,
          (in_flight && cur_op == 3'd0) || (m_halted && !(in_flight && cur_op == 3'd1)));
    end
  end

  // k: cycles the HART leaves the wait state unanswered; no_ack: never answer.
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wd,
                        input int k, input bit no_ack);
    int   lat;
    int   c;
    bit   waits;
    bus_t b;
    exp_err = 3'd0;
    exp_data = '0;
    exp_halted_after = m_halted;
    lat = 1;
    waits = 1'b0;
    case (op)
      3'd0: if (!m_halted) begin
        waits = 1'b1;
        if (no_ack) begin exp_err = 3'd4; lat = TO + 1; end
        else begin lat = k + 2; exp_halted_after = 1'b1; end
      end
      3'd1: if (!m_halted) exp_err = 3'd4;
      else begin
        waits = 1'b1;
        if (no_ack) begin exp_err = 3'd4; lat = TO + 1; end
        else begin lat = k + 2; exp_halted_after = 1'b0; end
      end
      3'd2, 3'd3: if (!m_halted) exp_err = 3'd4;
      else if (addr != 16'h07B0) exp_err = 3'd2;
      else begin
        lat = 2;
        b.rw = (op == 3'd3);
        b.wdata = wd;
        bus_q.push_back(b);
        if (op == 3'd2) exp_data = hart_rdata_i;
      end
      3'd4: if (!m_halted) exp_err = 3'd4;
      else begin
        waits = 1'b1;
        lat = k + 5;
        b.rw = 1'b0; b.wdata = '0;                      bus_q.push_back(b);
        b.rw = 1'b1; b.wdata = hart_rdata_i | 32'h4;    bus_q.push_back(b);
        b.rw = 1'b1; b.wdata = hart_rdata_i & ~32'h4;   bus_q.push_back(b);
      end
      default: exp_err = 3'd2;
    endcase
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_op_i = op;
    cmd_addr_i = addr;
    cmd_wdata_i = wd;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    cur_op = op;
    acc_cyc = cyc;
    exp_cyc = cyc + lat - 1;
    in_flight = 1'b1;
    if (waits && !no_ack) begin
      c = (op == 3'd4) ? k + 2 : k;
      repeat (c) @(posedge clk);
      #1;
      if (op == 3'd0) hart_halt_ack_i = 1'b1;
      else if (op == 3'd1) hart_resume_ack_i = 1'b1;
      else hart_stepping_i = 1'b1;
      @(posedge clk);
      #1;
      hart_halt_ack_i = 1'b0;
      hart_resume_ack_i = 1'b0;
      hart_stepping_i = 1'b0;
    end
    for (int i = 0; i < TO + 50 && in_flight; i++) @(posedge clk);
    @(negedge clk);
    chk("rsp_arrived", in_flight, 0);
    in_flight = 1'b0;
    $display("cmd op=%0d addr=%h wdata=%h -> err=%0d data=%h latency=%0d halted=%0b",
             op, addr, wd, rsp_err_o, rsp_data_o, last_lat, halted_o);
  endtask

  task automatic stray_pulse(input bit halt_ack, input bit resume_ack);
    @(posedge clk);
    #1;
    hart_halt_ack_i = halt_ack;
    hart_resume_ack_i = resume_ack;
    @(posedge clk);
    #1;
    hart_halt_ack_i = 1'b0;
    hart_resume_ack_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_halted"}, halted_o, 0);
    chk({tag, "_halt_req"}, hart_halt_req_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_data"}, rsp_data_o, 0);
    chk({tag, "_rsp_err"}, rsp_err_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ready"}, cmd_ready_o, 1);
    chk({tag, "_rd_wr_en"}, hart_rd_wr_en_o, 0);
    chk({tag, "_rd_wr"}, hart_rd_wr_o, 0);
    chk({tag, "_addr"}, hart_addr_o, 0);
    chk({tag, "_wdata"}, hart_wdata_o, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    reset_i = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    do_cmd(3'd2, 16'h07B0, 32'h0, 0, 1'b0);               // READ while running -> 4
    stray_pulse(1'b1, 1'b1);                               // ignored in IDLE
    do_cmd(3'd0, 16'h0, 32'h0, 3, 1'b0);                   // HALT, ack after 3
    chk("halt_latency_lit", last_lat, 5);
    chk("halted_lit", halted_o, 1);
    do_cmd(3'd0, 16'h0, 32'h0, 0, 1'b0);                   // already halted
    hart_rdata_i = 32'h4000_0063;
    do_cmd(3'd2, 16'h07B0, 32'h0, 0, 1'b0);
    chk("read_data_lit", rsp_data_o, 32'h4000_0063);
    chk("read_latency_lit", last_lat, 2);
    do_cmd(3'd3, 16'h07B1, 32'h1234_5678, 0, 1'b0);        // unsupported addr
    chk("bad_addr_err_lit", rsp_err_o, 3'd2);
    do_cmd(3'd3, 16'h07B0, 32'hDEAD_BEEF, 0, 1'b0);
    do_cmd(3'd5, 16'h07B0, 32'h0, 0, 1'b0);                // reserved ops
    do_cmd(3'd7, 16'h0000, 32'h0, 0, 1'b0);
    stray_pulse(1'b0, 1'b1);                               // resume ack ignored in IDLE
    hart_rdata_i = 32'h4000_0003;
    wr_log.delete();
    do_cmd(3'd4, 16'h0, 32'h0, 4, 1'b0);                   // STEP, stepping after 4
    chk("step_writes_lit", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("step_set_lit", wr_log[0], 32'h4000_0007);
      chk("step_clr_lit", wr_log[1], 32'h4000_0003);
    end
    chk("step_latency_lit", last_lat, 9);
    chk("step_halted_lit", halted_o, 1);
    do_cmd(3'd1, 16'h0, 32'h0, 2, 1'b0);                   // RESUME
    chk("resume_halted_lit", halted_o, 0);
    chk("resume_latency_lit", last_lat, 4);
    do_cmd(3'd1, 16'h0, 32'h0, 0, 1'b0);                   // second RESUME -> 4
    chk("resume_twice_err_lit", rsp_err_o, 3'd4);
    do_cmd(3'd4, 16'h0, 32'h0, 0, 1'b0);                   // STEP while running -> 4
`ifdef DM_HART_CTRL_TIMEOUT_EN
    do_cmd(3'd0, 16'h0, 32'h0, 0, 1'b1);                   // HALT with no ack
    chk("halt_timeout_latency_lit", last_lat, 9);
    chk("halt_timeout_err_lit", rsp_err_o, 3'd4);
    chk("halt_timeout_req_lit", hart_halt_req_o, 0);
`endif

    // Reset in the middle of HALT_WAIT abandons the command.
    chk_en = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_op_i = 3'd0;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_halt_req", hart_halt_req_o, 1);
    chk("pre_reset_busy", busy_o, 1);
    #2;
    reset_i = 1'b0;
    #1;
    chk_reset_values("midcmd_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    in_flight = 1'b0;
    bus_q.delete();
    m_halted = 1'b0;
    chk_en = 1'b1;
    repeat (6) @(negedge clk);
    do_cmd(3'd0, 16'h0, 32'h0, 0, 1'b0);                   // HALT, immediate ack
    chk("post_reset_halt_latency_lit", last_lat, 2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_hart_ctrl.md
# dm_hart_ctrl

Debug-module-side sequencer that drives the HART debug interface. It accepts one abstract command at a time (halt, resume, register read, register write, single-step) from the DMI register block. It then performs the halt-request / register-access / step / resume handshakes with the HART and returns a single response with data and cmderr. It sits between the DMI register file and the HART, and owns the HART's halt-request level.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: watchdog limit for any wait on the HART (halt ack, stepping, resume ack); minimum 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  3  0=HALT 1=RESUME 2=READ 3=WRITE 4=STEP, others reserved
- cmd_addr_i  in  16  register address (READ/WRITE)
- cmd_wdata_i  in  32  write data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_data_o  out  32  read data; 0 for non-READ; held until next response
- rsp_err_o  out  3  cmderr: 0 none, 2 not supported, 4 halt/resume state error
- halted_o  out  1  HART is in debug mode
- busy_o  out  1  command in progress (state != IDLE)
- hart_halt_req_o  out  1  level halt request to HART
- hart_rd_wr_en_o  out  1  register access strobe
- hart_rd_wr_o  out  1  1=write, 0=read
- hart_addr_o  out  16  register address
- hart_wdata_o  out  32  write data; top level drives the HART inout bus with it when hart_rd_wr_en_o&hart_rd_wr_o
- hart_rdata_i  in  32  HART inout bus as seen by the controller
- hart_halt_ack_i  in  1  HART halt acknowledge (halt_req & instruction complete)
- hart_resume_ack_i  in  1  one-cycle HART resume acknowledge
- hart_stepping_i  in  1  HART in STEPPING state

## Operation
- States: IDLE, HALT_WAIT, REG_ACC, STEP_RD, STEP_SET, STEP_WAIT, STEP_CLR, RESUME_WAIT, RESP.
- IDLE: cmd_ready_o=1. On accept, latch op/addr/wdata and dispatch:
  - HALT: if halted → RESP err 0; else → HALT_WAIT.
  - RESUME: if not halted → RESP err 4; else → RESUME_WAIT.
  - READ/WRITE: if not halted → err 4; if addr != DCSR_ADDR (16'h07B0) → err 2; else → REG_ACC.
  - STEP: if not halted → err 4; else → STEP_RD.
  - reserved op → RESP err 2.
- hart_halt_req_o = (state==HALT_WAIT) | (halted & state!=RESUME_WAIT).
- HALT_WAIT: on hart_halt_ack_i, set halted and go to RESP err 0.
- REG_ACC: drive hart_rd_wr_en_o=1 for exactly one cycle, with hart_addr_o=DCSR_ADDR. READ captures hart_rdata_i at the end of that cycle; WRITE drives hart_wdata_o. → RESP.
- STEP:
  - STEP_RD: one-cycle read of dcsr into a shadow register.
  - STEP_SET: one-cycle write of shadow with bit DCSR_STEP_BIT (2) set.
  - STEP_WAIT: wait for hart_stepping_i=1.
  - STEP_CLR: one-cycle write of shadow with bit 2 cleared. → RESP err 0. halted remains 1 throughout.
- RESUME_WAIT: halt request deasserted; on hart_resume_ack_i, clear halted and go to RESP err 0.
- RESP: rsp_valid_o=1 for one cycle, then → IDLE.
- hart_rd_wr_en_o is 0 in every state except REG_ACC, STEP_RD, STEP_SET and STEP_CLR.

## Timing
- Reset values:
  - state IDLE, halted_o 0, hart_halt_req_o 0, rsp_valid_o 0, rsp_data_o 0, rsp_err_o 0.
  - all hart_* outputs 0; cmd_ready_o 1.
- Latency from accept edge to rsp_valid_o:
  - immediate-error / already-halted: 1 cycle.
  - READ/WRITE: 2 cycles.
  - HALT: 2 cycles + ack wait.
  - STEP: 5 cycles + stepping wait.
- hart_halt_req_o rises the cycle after HALT is accepted.
- Ignored inputs: cmd_valid_i while busy; hart_halt_ack_i in IDLE; hart_resume_ack_i outside RESUME_WAIT.
- An async reset mid-command abandons the command with no response. hart_halt_req_o drops immediately.

## Configuration
- DM_HART_CTRL_TIMEOUT_EN defined:
  - HALT_WAIT, STEP_WAIT and RESUME_WAIT each count cycles from entry.
  - At TIMEOUT_CYCLES without the awaited input → RESP err 4.
  - HALT timeout leaves halted=0, so the halt request drops.
  - STEP timeout still passes through STEP_CLR before RESP, to clear the step bit.
  - RESUME timeout leaves halted=1, so the halt request is reasserted.
- Undefined: the waits are unbounded and the counter logic is absent.

## Structure
- Package dm_hart_ctrl_pkg holds:
  - op enum, state enum, cmderr localparams.
  - DCSR_ADDR and DCSR_STEP_BIT.
- Sub-module dm_hart_ctrl_timer holds the clear/enable/expired counter. It is instantiated only under DM_HART_CTRL_TIMEOUT_EN.

## Test plan
- HALT with hart_halt_ack_i after 3 cycles → hart_halt_req_o high from accept+1; rsp_valid_o at accept+5, err 0; halted_o 1.
- READ addr 16'h07B0 while halted, hart_rdata_i=32'h4000_0063 → one-cycle strobe with rd_wr=0; rsp_data_o=32'h4000_0063 at accept+2.
- WRITE addr 16'h07B1 while halted → no strobe, rsp err 2. READ while running → err 4.
- STEP with shadow 32'h4000_0003, stepping after 4 cycles → writes 32'h4000_0007 then 32'h4000_0003; err 0; halted_o stays 1.
- RESUME → hart_halt_req_o low, then resume ack → halted_o 0, err 0. Second RESUME → err 4.
- With DM_HART_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, HALT with no ack → err 4 at 8 cycles, halt request dropped. Reset asserted in HALT_WAIT → all outputs at reset values.
